pixel_pipeline: RTL

PIXEL_PIPELINE -- requirements
Module: pixel_pipeline

---
 rtl/vga_pkg.sv | 31 +++
 rtl/pixel_pipeline_if.sv | 21 ++
 rtl/pixel_pipeline_palette_bank.sv | 44 ++++
 rtl/pixel_pipeline.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ============================================================================
//  Package : vga_pkg
//  Shared types and helpers for the pixel pipeline: packed RGB colour,
//  pipeline latency, palette depth and grayscale palette initialiser.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int PIPE_LAT  = 3;
  localparam int PAL_DEPTH = 16;

  // Grayscale ramp: entry i = i*17 per channel, i.e. the nibble repeated.
  function automatic rgb_t gray_init(input logic [3:0] idx);
    rgb_t c;
    c.r = {idx, idx};
    c.g = {idx, idx};
    c.b = {idx, idx};
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_pipeline_if.sv
// ============================================================================
//  Interface : pixel_pipeline_if
//  Palette write/commit bus between the pipeline top and the palette bank.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_pipeline_if;
  import vga_pkg::*;

  logic       we;
  logic [3:0] idx;
  rgb_t       rgb;
  logic       commit;

  modport master (output we, idx, rgb, commit);
  modport slave  (input  we, idx, rgb, commit);

endinterface

`default_nettype wire

// File: rtl/pixel_pipeline_palette_bank.sv
// ============================================================================
//  Module  : palette_bank
//  Double-buffered 16-entry palette. Writes land in the shadow copy; a commit
//  copies every shadow entry into the active copy, which is read async.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_bank
  import vga_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  pixel_pipeline_if.slave       wr,
  input  logic [3:0]            rd_idx,
  output rgb_t                  rd_rgb
);

  rgb_t active_w [PAL_DEPTH];

  for (genvar gi = 0; gi < PAL_DEPTH; gi++) begin : g_entry
    rgb_t shadow_q;
    rgb_t active_q;

    // One palette slot: commit samples the pre-write shadow, so a write on
    // the commit edge is held back for the following commit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= gray_init(4'(gi));
        active_q <= gray_init(4'(gi));
      end else begin
        if (wr.commit) active_q <= shadow_q;
        if (wr.we && (wr.idx == 4'(gi))) shadow_q <= wr.rgb;
      end
    end

    assign active_w[gi] = active_q;
  end

  assign rd_rgb = active_w[rd_idx];

endmodule

`default_nettype wire

// File: rtl/pixel_pipeline.sv
// ============================================================================
//  Module  : pixel_pipeline
//  Three-stage VGA pixel path: framebuffer address, palette index capture,
//  palette lookup to RGB, with timing signals delayed to match.
//  Optional: PIXEL_PIPELINE_TEST_PATTERN_EN adds test_en and colour bars.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_pipeline
  import vga_pkg::*;
#(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic        vgaclk,
  input  logic        reset_b,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_b_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [14:0] fb_addr,
  input  logic [3:0]  fb_rdata,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [23:0] pal_rgb,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_b,
  output logic        sync_b,
`ifdef PIXEL_PIPELINE_TEST_PATTERN_EN
  input  logic        test_en,
`endif
  output logic [7:0]  frame_cnt
);

  if (FB_W * FB_H > 32768) begin : g_fb_size_check
    $error("pixel_pipeline: framebuffer does not fit a 15-bit address");
  end

  // Stage registers
  logic [14:0] fb_addr_q, fb_addr_d;
  logic        blank1_q, hs1_q, vs1_q;
  logic [3:0]  idx2_q;
  logic        blank2_q, hs2_q, vs2_q;
  rgb_t        rgb_q, rgb_d;
  logic        blank3_q, hs3_q, vs3_q;
  logic        vs_hist_q;
  logic [7:0]  frame_q;
  rgb_t        pal_rd_w;
  logic        w_commit;
  logic [9:0]  w_row, w_col;

`ifdef PIXEL_PIPELINE_TEST_PATTERN_EN
  logic [9:0]  x1_q, x2_q;
  logic [2:0]  w_bar;
`endif

  assign w_row    = y >> 2;
  assign w_col    = x >> 2;
  assign w_commit = vs_hist_q & ~vsync_in;

  // Framebuffer address: constant multiply, zero during blanking
  always_comb begin
    fb_addr_d = '0;
    if (blank_b_in)
      fb_addr_d = 15'(15'(w_row) * 15'(FB_W)) + 15'(w_col);
  end

  pixel_pipeline_if pal_bus ();

  assign pal_bus.we     = pal_we;
  assign pal_bus.idx    = pal_idx;
  assign pal_bus.rgb    = rgb_t'(pal_rgb);
  assign pal_bus.commit = w_commit;

  palette_bank u_palette_bank (
    .clk    (vgaclk),
    .rst_n  (reset_b),
    .wr     (pal_bus),
    .rd_idx (idx2_q),
    .rd_rgb (pal_rd_w)
  );

`ifdef PIXEL_PIPELINE_TEST_PATTERN_EN
  assign w_bar = x2_q[9:7];
`endif

  // Stage-3 colour select: palette (or test bars), forced black when blanked
  always_comb begin
    rgb_d = '0;
    if (blank2_q) begin
      rgb_d = pal_rd_w;
`ifdef PIXEL_PIPELINE_TEST_PATTERN_EN
      if (test_en)
        rgb_d = {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
`endif
    end
  end

  // Pipeline stages and delayed timing; syncs idle high, blank idles low
  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      fb_addr_q <= '0;
      blank1_q  <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      idx2_q    <= '0;
      blank2_q  <= 1'b0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      rgb_q     <= '0;
      blank3_q  <= 1'b0;
      hs3_q     <= 1'b1;
      vs3_q     <= 1'b1;
    end else begin
      fb_addr_q <= fb_addr_d;
      blank1_q  <= blank_b_in;
      hs1_q     <= hsync_in;
      vs1_q     <= vsync_in;
      idx2_q    <= fb_rdata;
      blank2_q  <= blank1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      rgb_q     <= rgb_d;
      blank3_q  <= blank2_q;
      hs3_q     <= hs2_q;
      vs3_q     <= vs2_q;
    end
  end

`ifdef PIXEL_PIPELINE_TEST_PATTERN_EN
  // Column carried alongside the pipeline for the bar pattern
  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      x1_q <= '0;
      x2_q <= '0;
    end else begin
      x1_q <= x;
      x2_q <= x1_q;
    end
  end
`endif

  // Vsync falling-edge detector and frame (commit) counter
  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      vs_hist_q <= 1'b1;
      frame_q   <= '0;
    end else begin
      vs_hist_q <= vsync_in;
      if (w_commit) frame_q <= frame_q + 8'd1;
    end
  end

  assign fb_addr   = fb_addr_q;
  assign vga_r     = rgb_q.r;
  assign vga_g     = rgb_q.g;
  assign vga_b     = rgb_q.b;
  assign hsync     = hs3_q;
  assign vsync     = vs3_q;
  assign blank_b   = blank3_q;
  assign sync_b    = 1'b0;
  assign frame_cnt = frame_q;

endmodule

`default_nettype wire
